sync_fifo_level: RTL

SYNC_FIFO_LEVEL -- requirements
Module: sync_fifo_level

---
 rtl/sync_fifo_level.sv | 89 ++++++++
 1 files changed

// File: rtl/sync_fifo_level.sv
// Single-clock FIFO with wrap-bit pointers, a level output, threshold flags,
// and sticky overflow/underflow error bits. Read data is registered (1-cycle latency).
module sync_fifo_level #(
    parameter int WIDTH     = 8,
    parameter int ADDR_W    = 8,
    parameter int AFULL_TH  = (1 << ADDR_W) - 4,
    parameter int AEMPTY_TH = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              w_en,
    input  logic [WIDTH-1:0]  data_in,
    input  logic              r_en,
    output logic [WIDTH-1:0]  data_out,
    output logic              full_flag,
    output logic              empty_flag,
    output logic [ADDR_W:0]   level,
    output logic              almost_full,
    output logic              almost_empty,
    output logic              overflow,
    output logic              underflow
);

    localparam int DEPTH = 1 << ADDR_W;
    localparam logic [ADDR_W:0] DEPTH_L  = DEPTH[ADDR_W:0];
    localparam logic [ADDR_W:0] AFULL_L  = AFULL_TH[ADDR_W:0];
    localparam logic [ADDR_W:0] AEMPTY_L = AEMPTY_TH[ADDR_W:0];

    logic [WIDTH-1:0]  r_mem [DEPTH];
    logic [ADDR_W:0]   r_wptr;
    logic [ADDR_W:0]   r_rptr;
    logic [WIDTH-1:0]  r_data_out;
    logic              r_overflow;
    logic              r_underflow;

    logic [ADDR_W:0]   w_level;
    logic              w_full;
    logic              w_empty;
    logic              w_wr_accept;
    logic              w_rd_accept;

    // The MSB wrap bit makes the modular difference span 0..DEPTH unambiguously.
    assign w_level     = r_wptr - r_rptr;
    assign w_full      = (w_level == DEPTH_L);
    assign w_empty     = (w_level == '0);
    assign w_wr_accept = w_en && !w_full;
    assign w_rd_accept = r_en && !w_empty;

    // Storage has no reset so it maps onto block RAM.
    always_ff @(posedge clk) begin
        if (w_wr_accept && !rst) begin
            r_mem[r_wptr[ADDR_W-1:0]] <= data_in;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wptr      <= '0;
            r_rptr      <= '0;
            r_data_out  <= '0;
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else begin
            if (w_wr_accept) begin
                r_wptr <= r_wptr + 1'b1;
            end
            if (w_rd_accept) begin
                r_data_out <= r_mem[r_rptr[ADDR_W-1:0]];
                r_rptr     <= r_rptr + 1'b1;
            end
            if (w_en && w_full) begin
                r_overflow <= 1'b1;
            end
            if (r_en && w_empty) begin
                r_underflow <= 1'b1;
            end
        end
    end

    assign data_out     = r_data_out;
    assign level        = w_level;
    assign full_flag    = w_full;
    assign empty_flag   = w_empty;
    assign almost_full  = (w_level >= AFULL_L);
    assign almost_empty = (w_level <= AEMPTY_L);
    assign overflow     = r_overflow;
    assign underflow    = r_underflow;

endmodule
